// File: rtl/bully_mem_pkg.sv
// Shared definitions for the strobed RAM: controller state encodings and the
// width helper used to size the clear counter and the word index.
package bully_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Smallest w with 2**w >= value; used for counter and index widths.
    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Extra read-return stages: delays {valid, err, data} by STAGES cycles while
// holding data steady and keeping err low whenever valid is low.
module ram_read_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             i_valid,
    input  logic             i_err,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic             o_err,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign o_valid = i_valid;
            assign o_err   = i_err;
            assign o_data  = i_data;
        end else begin : g_stages
            logic [STAGES-1:0] r_valid;
            logic [STAGES-1:0] r_err;
            logic [WIDTH-1:0]  r_data [STAGES];

            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    r_valid <= '0;
                    r_err   <= '0;
                    for (int i = 0; i < STAGES; i++) begin
                        r_data[i] <= '0;
                    end
                end else begin
                    r_valid[0] <= i_valid;
                    r_err[0]   <= i_valid & i_err;
                    if (i_valid) begin
                        r_data[0] <= i_data;
                    end
                    for (int i = 1; i < STAGES; i++) begin
                        r_valid[i] <= r_valid[i-1];
                        r_err[i]   <= r_valid[i-1] & r_err[i-1];
                        if (r_valid[i-1]) begin
                            r_data[i] <= r_data[i-1];
                        end
                    end
                end
            end

            assign o_valid = r_valid[STAGES-1];
            assign o_err   = r_err[STAGES-1];
            assign o_data  = r_data[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/ram_memory_strobed.sv
// Byte-strobed single-clock RAM with range-checked word addressing, a
// post-reset clearing sweep, write-first collisions and 1- or 2-cycle reads.
module ram_memory_strobed
    import bully_mem_pkg::*;
#(
    parameter int BUS_WIDTH    = 32,
    parameter int ADDR_BASE    = 0,
    parameter int MEM_SIZE     = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   write_en,
    input  logic [BUS_WIDTH/8-1:0] write_strb,
    input  logic [BUS_WIDTH-1:0]   addr_write,
    input  logic [BUS_WIDTH-1:0]   data_write,
    output logic                   write_err,
    input  logic                   read_req,
    input  logic [BUS_WIDTH-1:0]   addr_read,
    output logic [BUS_WIDTH-1:0]   data_read,
    output logic                   read_valid,
    output logic                   read_err,
    output logic                   ready
);

    localparam int STRB_W = BUS_WIDTH / 8;
    localparam int IDX_W  = log2_ceil(MEM_SIZE);
    // One spare bit so MEM_SIZE itself is representable in the range compare.
    localparam int CMP_W  = ((BUS_WIDTH > IDX_W) ? BUS_WIDTH : IDX_W) + 1;

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("ram_memory_strobed: READ_LATENCY must be 1 or 2");
        end
        if (BUS_WIDTH < 8 || (BUS_WIDTH % 8) != 0) begin : g_bad_width
            $error("ram_memory_strobed: BUS_WIDTH must be a non-zero multiple of 8");
        end
        if (MEM_SIZE < 2) begin : g_bad_size
            $error("ram_memory_strobed: MEM_SIZE must be at least 2");
        end
    endgenerate

    logic [BUS_WIDTH-1:0] w_wr_offset;
    logic [BUS_WIDTH-1:0] w_rd_offset;
    logic                 w_wr_in_range;
    logic                 w_rd_in_range;
    logic [IDX_W-1:0]     w_wr_idx;
    logic [IDX_W-1:0]     w_rd_idx;

    // Unsigned wrap: addresses below ADDR_BASE land far above MEM_SIZE.
    assign w_wr_offset   = addr_write - BUS_WIDTH'(ADDR_BASE);
    assign w_rd_offset   = addr_read  - BUS_WIDTH'(ADDR_BASE);
    assign w_wr_in_range = CMP_W'(w_wr_offset) < CMP_W'(MEM_SIZE);
    assign w_rd_in_range = CMP_W'(w_rd_offset) < CMP_W'(MEM_SIZE);
    assign w_wr_idx      = IDX_W'(w_wr_offset);
    assign w_rd_idx      = IDX_W'(w_rd_offset);

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_clr_cnt;
    logic             w_clr_last;
    logic             w_clearing;
    logic             w_wr_fire;
    logic             w_wr_oob;
    logic             w_rd_fire;

    assign w_clr_last = (r_clr_cnt == IDX_W'(MEM_SIZE - 1));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == CLEAR && !w_clr_last) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_clearing   = 1'b0;
        w_wr_fire    = 1'b0;
        w_wr_oob     = 1'b0;
        w_rd_fire    = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clearing = 1'b1;
                if (w_clr_last) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_wr_fire = write_en & w_wr_in_range;
                w_wr_oob  = write_en & ~w_wr_in_range;
                w_rd_fire = read_req;
            end
            default: w_next_state = CLEAR;
        endcase
    end

    assign ready = (r_state == RUN);

    logic [BUS_WIDTH-1:0] r_mem [MEM_SIZE];

    // NOTE: the array has no reset branch; the CLEAR sweep zeroes it one word per cycle.
    always_ff @(posedge clk) begin
        if (w_clearing) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_fire) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (write_strb[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= data_write[8*b +: 8];
                end
            end
        end
    end

    logic [BUS_WIDTH-1:0] w_rd_word;

    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        if (w_wr_fire && (w_wr_idx == w_rd_idx)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (write_strb[b]) begin
                    w_rd_word[8*b +: 8] = data_write[8*b +: 8];
                end
            end
        end
    end

    logic                 r_rd_valid;
    logic                 r_rd_err;
    logic [BUS_WIDTH-1:0] r_rd_data;
    logic                 r_wr_err;

    // NOTE: registered state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_data  <= '0;
            r_wr_err   <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            r_rd_err   <= w_rd_fire & ~w_rd_in_range;
            r_wr_err   <= w_wr_oob;
            if (w_rd_fire) begin
                r_rd_data <= w_rd_in_range ? w_rd_word : '0;
            end
        end
    end

    assign write_err = r_wr_err;

    ram_read_pipe #(
        .WIDTH  (BUS_WIDTH),
        .STAGES (READ_LATENCY - 1)
    ) u_read_pipe (
        .clk     (clk),
        .nreset  (nreset),
        .i_valid (r_rd_valid),
        .i_err   (r_rd_err),
        .i_data  (r_rd_data),
        .o_valid (read_valid),
        .o_err   (read_err),
        .o_data  (data_read)
    );

endmodule
